// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider for DIV/DIVU.
// It produces one quotient bit per clock. The quotient goes to Q (LO) and the
// remainder goes to R (HI).
// Optional feature macro: SEQ_DIV_EARLY_EXIT_EN. When it is defined, a
// divisor larger than the dividend skips the shift/subtract loop.
//
// Handshake: start is accepted only while the FSM is in IDLE (busy=0, done=0).
// An accepted start captures A, B and is_signed in that same cycle, and the
// inputs are free to change afterwards. busy stays high while the loop and the
// sign fix-up run. done pulses for exactly one cycle when Q/R/div_by_zero are
// valid. Q and R hold their values until the next result overwrites them.
// Any start that arrives outside IDLE, including the DONE cycle, is ignored.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;     // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dvs;     // divisor magnitude
  logic [WIDTH-1:0] rem;     // partial remainder, always below dvs
  logic [WIDTH-1:0] quot;    // quotient magnitude, built LSB-in
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_sh;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx;

  // Operand magnitudes; two's complement negation only in signed mode
  always_comb begin
    abs_a = (is_signed && A[WIDTH-1]) ? (ZERO - A) : A;
    abs_b = (is_signed && B[WIDTH-1]) ? (ZERO - B) : B;
  end

  // One restoring step: shift in the next dividend bit, then subtract the
  // divisor if it fits. The shifted remainder is one bit wider, so the compare
  // cannot overflow. When the subtract happens, its result is below dvs, so the
  // low WIDTH bits are enough to hold it.
  always_comb begin
    rem_sh = {rem, dvd[WIDTH-1]};
    q_bit  = (rem_sh >= {1'b0, dvs});
    rem_nx = q_bit ? (rem_sh[WIDTH-1:0] - dvs) : rem_sh[WIDTH-1:0];
  end

`ifdef SEQ_DIV_EARLY_EXIT_EN
  logic early_exit;
  // The quotient is zero whenever the divisor magnitude exceeds the dividend's
  always_comb begin
    early_exit = (B != ZERO) && (abs_b > abs_a);
  end
`endif

  // Control FSM plus the datapath registers it sequences
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      quot        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            sign_q      <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            sign_r      <= is_signed & A[WIDTH-1];
            dvd         <= abs_a;
            dvs         <= abs_b;
            rem         <= '0;
            quot        <= '0;
            cnt         <= '0;
            if (B == ZERO) begin
              // Defined but architecturally unpredictable result
              Q           <= ALL_ONES;
              R           <= A;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
`ifdef SEQ_DIV_EARLY_EXIT_EN
            else if (early_exit) begin
              rem   <= abs_a;
              state <= FIX;
            end
`endif
            else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem  <= rem_nx;
          dvd  <= {dvd[WIDTH-2:0], 1'b0};
          quot <= {quot[WIDTH-2:0], q_bit};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) state <= FIX;
        end
        FIX: begin
          // Truncation toward zero; the remainder follows the dividend's sign
          Q     <= sign_q ? (ZERO - quot) : quot;
          R     <= sign_r ? (ZERO - rem) : rem;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status decoded straight from the state register
  always_comb begin
    busy      = (state == RUN) || (state == FIX);
    done      = (state == DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider. Latency is counted in clock cycles after
// the edge that samples start, and is checked at the falling edge on which
// done is first seen high.
module tb_seq_divider;

  localparam int W = 32;
  // The loop path takes 32 RUN cycles plus FIX, so done shows up in the 34th cycle
  localparam int LAT_FULL = 34;
  // A zero divisor goes IDLE -> DONE, so done is already high in the first cycle
  localparam int LAT_DBZ  = 1;
`ifdef SEQ_DIV_EARLY_EXIT_EN
  localparam int LAT_SMALL = 2;   // IDLE -> FIX -> DONE
`else
  localparam int LAT_SMALL = LAT_FULL;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic [1:0]   state_dbg;

  int n_vec  = 0;
  int n_miss = 0;

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .Q           (Q),
    .R           (R),
    .state_dbg   (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle, then scramble the inputs to prove they were captured.
  // Returns at the falling edge of the first cycle after the sampling edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    A = a; B = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom; is_signed = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) for done; lat0 is the cycle number of the current falling edge
  task automatic wait_done(input int lat0, output int lat, output int busy_n);
    lat = lat0; busy_n = 0;
    while (!done && lat < 200) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  // Full division with latency, result and pulse-width checks
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input int elat);
    int lat, bn;
    launch(a, b, s);
    wait_done(1, lat, bn);
    check({tag, "_lat"}, W'(lat), W'(elat));
    check({tag, "_q"}, Q, eq);
    check({tag, "_r"}, R, er);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    @(negedge clk);
    check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    check({tag, "_q_hold"}, Q, eq);
  endtask

  initial begin
    int lat, bn, seen;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_q", Q, 32'd0);
    check("rst_r", R, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);

    // Unsigned main case, with the busy-cycle count checked explicitly
    launch(32'd100000000, 32'd100, 1'b0);
    wait_done(1, lat, bn);
    check("u1_lat", W'(lat), W'(LAT_FULL));
    check("u1_busy_cycles", W'(bn), 32'd33);
    check("u1_q", Q, 32'd1000000);
    check("u1_r", R, 32'd0);
    @(negedge clk);
    check("u1_done_1cyc", {31'd0, done}, 32'd0);

    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT_FULL);
    run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, LAT_FULL);
    run_div("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, LAT_FULL);
    run_div("dbz", 32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, LAT_DBZ);

    // The next accepted start clears the divide-by-zero flag
    launch(32'd10, 32'd3, 1'b0);
    check("dbz_clear", {31'd0, div_by_zero}, 32'd0);
    wait_done(1, lat, bn);
    check("dbz_next_q", Q, 32'd3);
    check("dbz_next_r", R, 32'd1);

    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, LAT_FULL);
    run_div("u_max", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT_FULL);
    run_div("u_big_dvs", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, LAT_SMALL);
    run_div("u_fff_16", 32'hFFFF_FFFF, 32'd16, 1'b0, 32'h0FFF_FFFF, 32'd15, 1'b0, LAT_FULL);
    run_div("small_5_9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, LAT_SMALL);
    run_div("s_m5_9", 32'hFFFF_FFFB, 32'd9, 1'b1, 32'd0, 32'hFFFF_FFFB, 1'b0, LAT_SMALL);

    // A start mid-run must not recapture the operands
    launch(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    A = 32'd50; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, lat, bn);
    check("ign_lat", W'(lat), W'(LAT_FULL));
    check("ign_q", Q, 32'd14);
    check("ign_r", R, 32'd2);

    // A start in the DONE cycle is dropped
    A = 32'd9; B = 32'd4; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("done_start_idle", {30'd0, state_dbg}, 32'd0);
    check("done_start_q", Q, 32'd14);

    // Reset mid-run abandons the division silently
    launch(32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_q", Q, 32'd0);
    check("mrst_r", R, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("mrst_no_done", W'(seen), 32'd0);
    run_div("mrst_fresh", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, LAT_FULL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
